// File: rtl/ecg_pkg.sv
// ecg_pkg: shared constants and state encoding for the ECG slot scheduler.
package ecg_pkg;
    localparam int NUM_ECG = 4;
    localparam logic [1:0] SSI_444  = 2'd0;
    localparam logic [1:0] SSI_422  = 2'd1;
    localparam logic [1:0] SSI_420  = 2'd2;
    localparam logic [1:0] SSI_RSVD = 2'd3;
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
endpackage

// File: rtl/ecg_scheduler_if.sv
// ecg_scheduler_if: block control, config and downstream slot handshake of the ECG scheduler.
interface ecg_scheduler_if;
    logic       start;
    logic [1:0] sub_sample_info;
    logic [3:0] component_skip;
    logic       ecg_ready;
    logic       ecg_valid;
    logic [1:0] ecgidx;
    logic [1:0] component_idx;
    logic       data_active;
    logic       busy;
    logic       block_done;
    logic [3:0] active_cnt;
    logic       cfg_err;
    modport master (
        input  start, sub_sample_info, component_skip, ecg_ready,
        output ecg_valid, ecgidx, component_idx, data_active, busy, block_done, active_cnt, cfg_err
    );
    modport slave (
        output start, sub_sample_info, component_skip, ecg_ready,
        input  ecg_valid, ecgidx, component_idx, data_active, busy, block_done, active_cnt, cfg_err
    );
endinterface

// File: rtl/ecg_DataActive.sv
// ecg_DataActive: decides whether an ECG slot carries coded data for the given subsampling mode.
module ecg_DataActive
    import ecg_pkg::*;
(
    input  logic [1:0] ssi,
    input  logic [1:0] comp,
    input  logic [1:0] ecg,
    input  logic [3:0] skip,
    output logic       active
);
    logic chroma;
    always_comb begin
        chroma = comp == 2'd1 || comp == 2'd2;
        active = !skip[comp] && (!chroma || ssi == SSI_444 ||
                 (ssi == SSI_422 && ecg < 2'd2) || (ssi == SSI_420 && ecg == 2'd0));
    end
endmodule

// File: rtl/ecg_slot_counter.sv
// ecg_slot_counter: nested component/ECG slot counter, exposing both current and next slot.
module ecg_slot_counter
    import ecg_pkg::*;
#(
    parameter int NUM_COMP = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       advance,
    output logic [1:0] comp,
    output logic [1:0] ecg,
    output logic [1:0] comp_n,
    output logic [1:0] ecg_n,
    output logic       last
);
    logic wrap;
    always_comb begin
        wrap   = ecg == 2'(NUM_ECG - 1);
        last   = wrap && comp == 2'(NUM_COMP - 1);
        ecg_n  = clear ? 2'd0 : advance ? (wrap ? 2'd0 : ecg + 2'd1) : ecg;
        comp_n = clear ? 2'd0 : (advance && wrap) ? comp + 2'd1 : comp;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) {comp, ecg} <= '0;
        else     {comp, ecg} <= {comp_n, ecg_n};
endmodule

// File: rtl/ecg_scheduler.sv
// ecg_scheduler: walks the ECG slots of one block and presents them downstream over valid/ready.
module ecg_scheduler
    import ecg_pkg::*;
#(
    parameter int NUM_COMP      = 3,
    parameter bit SKIP_INACTIVE = 1'b1
) (
    input logic             clk,
    input logic             rst,
    ecg_scheduler_if.master bus
);
    state_t     state, state_n;
    logic [1:0] ssi, ssi_n, comp_n, ecg_n;
    logic [3:0] skip, skip_n;
    logic       accept, fire, step, advance, last, act_n;
    ecg_slot_counter #(.NUM_COMP(NUM_COMP)) u_cnt (
        .clk(clk), .rst(rst), .clear(accept), .advance(advance),
        .comp(bus.component_idx), .ecg(bus.ecgidx),
        .comp_n(comp_n), .ecg_n(ecg_n), .last(last)
    );
    // Decode on next-cycle slot and config so valid/data_active can be registered.
    ecg_DataActive u_act (.ssi(ssi_n), .comp(comp_n), .ecg(ecg_n), .skip(skip_n), .active(act_n));
    always_comb begin
        accept  = state == IDLE && bus.start;
        fire    = bus.ecg_valid && bus.ecg_ready;
        step    = state == ISSUE && (fire || !bus.ecg_valid);
        advance = step && !last;
        ssi_n   = accept ? (bus.sub_sample_info == SSI_RSVD ? SSI_444 : bus.sub_sample_info) : ssi;
        skip_n  = accept ? bus.component_skip : skip;
        state_n = state;
        if (accept)                state_n = ISSUE;
        else if (step && last)     state_n = DONE;
        else if (state == DONE)    state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state           <= IDLE;
            ssi             <= SSI_444;
            skip            <= '0;
            bus.ecg_valid   <= 1'b0;
            bus.data_active <= 1'b0;
            bus.busy        <= 1'b0;
            bus.block_done  <= 1'b0;
            bus.active_cnt  <= '0;
            bus.cfg_err     <= 1'b0;
        end else begin
            state           <= state_n;
            ssi             <= ssi_n;
            skip            <= skip_n;
            bus.ecg_valid   <= state_n == ISSUE && (act_n || !SKIP_INACTIVE);
            bus.data_active <= state_n == ISSUE && act_n;
            bus.busy        <= state_n != IDLE;
            bus.block_done  <= state_n == DONE;
            bus.active_cnt  <= accept ? 4'd0 : bus.active_cnt + 4'(fire && bus.data_active);
            bus.cfg_err     <= accept ? bus.sub_sample_info == SSI_RSVD : bus.cfg_err;
        end
endmodule

// File: tb/tb_ecg_scheduler.sv
// tb_ecg_scheduler: directed checks of slot order, activity, backpressure and reset for both skip modes.
module tb_ecg_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [15:0] mask, mask0, da0;
    int ncyc, seen_hold, last_idx, first_idx;
    bit order_ok;
    ecg_scheduler_if b ();
    ecg_scheduler_if b0 ();
    assign b0.start           = b.start;
    assign b0.sub_sample_info = b.sub_sample_info;
    assign b0.component_skip  = b.component_skip;
    assign b0.ecg_ready       = b.ecg_ready;
    ecg_scheduler #(.NUM_COMP(3), .SKIP_INACTIVE(1'b1)) u_dut  (.clk(clk), .rst(rst), .bus(b));
    ecg_scheduler #(.NUM_COMP(3), .SKIP_INACTIVE(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask
    task automatic run(input logic [1:0] ssi, input logic [3:0] skp, input int hold_idx,
                       input int hold_n, input int busy_start_at);
        int idx, idx0, held;
        bit done;
        @(negedge clk);
        b.sub_sample_info = ssi;
        b.component_skip  = skp;
        b.ecg_ready       = 1'b1;
        b.start           = 1'b1;
        @(negedge clk);
        b.start = 1'b0;
        mask = '0; mask0 = '0; da0 = '0;
        ncyc = 0; seen_hold = 0; held = 0; last_idx = -1; first_idx = -1;
        order_ok = 1'b1; done = 1'b0;
        for (int i = 1; i < 40 && !done; i++) begin
            b.start = (i == busy_start_at);
            if (i == busy_start_at) b.sub_sample_info = 2'd2;
            idx  = int'(b.component_idx) * 4 + int'(b.ecgidx);
            idx0 = int'(b0.component_idx) * 4 + int'(b0.ecgidx);
            b.ecg_ready = 1'b1;
            if (b.ecg_valid) begin
                if (idx < last_idx) order_ok = 1'b0;
                if (first_idx < 0) first_idx = idx;
                last_idx  = idx;
                mask[idx] = 1'b1;
                if (idx == hold_idx) begin
                    seen_hold++;
                    if (held < hold_n) begin
                        b.ecg_ready = 1'b0;
                        held++;
                    end
                end
            end
            if (b0.ecg_valid) begin
                mask0[idx0] = 1'b1;
                if (b0.data_active) da0[idx0] = 1'b1;
            end
            if (b.block_done) begin
                ncyc = i;
                done = 1'b1;
            end
            @(negedge clk);
        end
        b.start = 1'b0;
    endtask
    task automatic check_block(input string name, input int e_mask, input int e_cnt,
                               input int e_da0, input int e_ncyc, input int e_err);
        chk({name, "_mask"}, int'(mask), e_mask);
        chk({name, "_order"}, int'(order_ok), 1);
        chk({name, "_done_cycle"}, ncyc, e_ncyc);
        chk({name, "_active_cnt"}, int'(b.active_cnt), e_cnt);
        chk({name, "_busy_after"}, int'(b.busy), 0);
        chk({name, "_cfg_err"}, int'(b.cfg_err), e_err);
        chk({name, "_all_mask0"}, int'(mask0), 'hFFF);
        chk({name, "_da0"}, int'(da0), e_da0);
        chk({name, "_active_cnt0"}, int'(b0.active_cnt), e_cnt);
    endtask
    initial begin
        int dones;
        b.start = 1'b0;
        b.sub_sample_info = 2'd0;
        b.component_skip = 4'd0;
        b.ecg_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_valid", int'(b.ecg_valid), 0);
        chk("reset_busy", int'(b.busy), 0);
        chk("reset_slot", int'({b.component_idx, b.ecgidx}), 0);
        chk("reset_cnt", int'(b.active_cnt), 0);
        rst = 1'b0;
        run(2'd0, 4'b0000, -1, 0, 0);
        check_block("ssi444", 'hFFF, 12, 'hFFF, 13, 0);
        chk("ssi444_first", first_idx, 0);
        run(2'd1, 4'b0000, -1, 0, 0);
        check_block("ssi422", 'h33F, 8, 'h33F, 13, 0);
        run(2'd2, 4'b0000, -1, 0, 0);
        check_block("ssi420", 'h11F, 6, 'h11F, 13, 0);
        run(2'd0, 4'b0010, -1, 0, 0);
        check_block("skip_c1", 'hF0F, 8, 'hF0F, 13, 0);
        run(2'd0, 4'b0111, -1, 0, 0);
        check_block("skip_all", 'h000, 0, 'h000, 13, 0);
        run(2'd0, 4'b0000, 4, 3, 2);
        check_block("backpressure", 'hFFF, 12, 'hFFF, 16, 0);
        chk("backpressure_held", seen_hold, 4);
        run(2'd3, 4'b0000, -1, 0, 0);
        check_block("ssi_rsvd", 'hFFF, 12, 'hFFF, 13, 1);
        run(2'd0, 4'b0000, -1, 0, 0);
        check_block("cfg_err_clear", 'hFFF, 12, 'hFFF, 13, 0);
        // Abort a block at slot (1,2); reset must act between clock edges.
        @(negedge clk);
        b.sub_sample_info = 2'd0;
        b.component_skip = 4'd0;
        b.start = 1'b1;
        @(negedge clk);
        b.start = 1'b0;
        for (int i = 0; i < 20 && !(b.ecg_valid && b.component_idx == 2'd1 && b.ecgidx == 2'd2); i++)
            @(negedge clk);
        chk("rst_reached_slot", int'({b.ecg_valid, b.component_idx, b.ecgidx}), 'b10110);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", int'(b.ecg_valid), 0);
        chk("rst_async_slot", int'({b.component_idx, b.ecgidx}), 0);
        chk("rst_async_busy", int'(b.busy), 0);
        chk("rst_async_cnt", int'(b.active_cnt), 0);
        chk("rst_async_active", int'(b.data_active), 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (16) begin
            @(negedge clk);
            if (b.block_done) dones++;
        end
        chk("rst_no_done", dones, 0);
        run(2'd0, 4'b0000, -1, 0, 0);
        check_block("after_rst", 'hFFF, 12, 'hFFF, 13, 0);
        chk("after_rst_first", first_idx, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ecg_scheduler.md
Name: ecg_scheduler

Overview:
Sequences the entropy-coding-group (ECG) slots of one block for the BP-mode ECG encoder. It walks component_idx and ecgidx in a fixed order and decides per slot whether data is active, from the chroma subsampling mode and the per-component skip flags. Each slot is presented to the downstream ECG coder over a valid/ready handshake. It sits between block-level control (start/config) and the per-ECG datapath.

Parameters:
NUM_COMP, 3, number of components iterated per block (legal 1..4)
NUM_ECG, 4, ECGs per component (fixed 4; ecgidx is 2 bits)
SKIP_INACTIVE, 1, 1 = inactive slots are not presented downstream; 0 = presented with data_active=0

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to schedule a block; sampled only in IDLE
sub_sample_info  input  2  0=4:4:4, 1=4:2:2, 2=4:2:0, 3=reserved; latched on accepted start
component_skip  input  4  per-component skip, bit c skips component c; latched on accepted start
ecg_ready  input  1  downstream accepts current slot
ecg_valid  output  1  slot presented
ecgidx  output  2  ECG index of presented slot
component_idx  output  2  component of presented slot
data_active  output  1  presented slot carries coded data
busy  output  1  high from accepted start until block_done inclusive
block_done  output  1  one-cycle pulse after last slot handshake
active_cnt  output  4  active slots in the block just finished; valid with block_done, held until next start
cfg_err  output  1  sticky until next accepted start; set when latched sub_sample_info==3

Behaviour:
- Reset (async, immediate): state=IDLE; ecg_valid, data_active, busy, block_done, cfg_err=0; ecgidx, component_idx=0; active_cnt=0.
- All outputs registered.
- States: IDLE -> ISSUE -> DONE -> IDLE.
- IDLE: start=1 latches config, clears the slot counter and active_cnt, sets cfg_err if ssi==3, sets busy, and goes to ISSUE. The first ecg_valid appears the next cycle (latency 1).
- Slot order: component_idx outer 0..NUM_COMP-1, ecgidx inner 0..3. This gives NUM_COMP*4 slots.
- Active rule (decoded by the existing ecg_DataActive; ssi 3 is mapped to 0 before it):
  - skip[c]=1 -> inactive.
  - ssi 0 -> active.
  - ssi 1 -> components 1,2 inactive at ecgidx 2,3.
  - ssi 2 -> components 1,2 inactive at ecgidx 1,2,3.
  - component 3 is always active unless skipped.
- ISSUE, SKIP_INACTIVE=1:
  - The counter advances past inactive slots internally, one slot per cycle, with ecg_valid=0.
  - An active slot asserts ecg_valid=1 with data_active=1.
- ISSUE, SKIP_INACTIVE=0: every slot is presented with ecg_valid=1.
- Handshake:
  - While ecg_valid && !ecg_ready, ecgidx, component_idx and data_active are held stable.
  - On ecg_valid && ecg_ready, the scheduler advances. The next slot may be valid in the following cycle, so one slot per cycle is sustained with ready tied high.
  - active_cnt increments on each handshake with data_active=1.
- The handshake on the last slot, or stepping past the last slot when it is inactive, moves the FSM to DONE. ecg_valid=0 from then on.
- DONE: block_done=1 for one cycle, busy stays 1, then IDLE with busy=0.
- start while busy is ignored; no queuing.
- ecg_ready while ecg_valid=0 is ignored.
- All components skipped with SKIP_INACTIVE=1: no ecg_valid; DONE is reached after NUM_COMP*4 stepping cycles; active_cnt=0.
- rst mid-block: immediate return to reset values. The partial block is discarded, with no block_done.
- Config inputs may change while busy without effect, because they are latched.

Decomposition:
- Package ecg_pkg holds:
  - SSI_444/SSI_422/SSI_420/SSI_RSVD constants.
  - State enum {IDLE, ISSUE, DONE}.
  - NUM_ECG constant.
- Sub-module ecg_slot_counter: nested ecgidx/component_idx counter with advance input and last-slot flag. Wrap is ecgidx 3->0 with component +1.
- Active decode reuses ecg_DataActive, instantiated on the counter outputs.

Test Plan:
- ssi=0, skip=0, ready=1, SKIP_INACTIVE=1 -> 12 consecutive valid cycles in order (0,0)..(2,3); block_done 13 cycles after start; active_cnt=12.
- ssi=1, skip=0 -> components 1,2 present only ecgidx 0,1; active_cnt=8; ssi=2 -> active_cnt=6; with SKIP_INACTIVE=0 all 12 presented, data_active=0 at the excluded slots.
- skip=4'b0010, ssi=0 -> component 1 never presented; active_cnt=8. skip=4'b0111 -> no ecg_valid; block_done after 12 stepping cycles; active_cnt=0.
- Backpressure: ready low for 3 cycles on slot (1,0) -> outputs stable, no advance; the order is intact after release; start pulsed while busy is ignored.
- ssi=3 -> cfg_err=1; schedule identical to ssi=0; cfg_err clears on the next accepted start.
- rst asserted at slot (1,2) -> all outputs zero asynchronously; no block_done; a subsequent start schedules a fresh block from (0,0).
